oiia_uart_tx: RTL and testbench

Byte-serial transmitter for the oiia_goose tile. It takes 8-bit result bytes over a valid/ready handshake and drives them off-chip on one output pin as asynchronous serial frames: start bit, 8 data bits LSB first, optional parity, 1 or 2 stop bits. It sits between the tile's result datapath (for example the ui_in + uio_in sum) and a uo_out pin, so a host UART receiver can read results.

---
 rtl/oiia_uart_tx.sv | 142 ++++++++++++++
 tb/tb_oiia_uart_tx.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/oiia_uart_tx.sv
// Serial byte transmitter: valid/ready byte input, one registered tx pin carrying
// start bit, 8 data bits LSB first, optional parity and 1 or 2 stop bits.
module oiia_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx,
    output logic       busy
);

    if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535) begin : g_bad_cpb
        $error("oiia_uart_tx: CLKS_PER_BIT must be in 2..65535");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
        $error("oiia_uart_tx: STOP_BITS must be 1 or 2");
    end
    if (PARITY_EN != 0 && PARITY_EN != 1) begin : g_bad_pen
        $error("oiia_uart_tx: PARITY_EN must be 0 or 1");
    end
    if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_podd
        $error("oiia_uart_tx: PARITY_ODD must be 0 or 1");
    end

    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic        HAS_PAR   = (PARITY_EN != 0);
    localparam logic        ODD_BIT   = (PARITY_ODD != 0);
    localparam logic        STOP_LAST = (STOP_BITS == 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t      state_q;
    logic [15:0] baud_q;
    logic [2:0]  bit_q;
    logic        stop_q;
    logic [7:0]  shift_q;
    logic        par_q;
    logic        tx_q;
    logic        busy_q;

    logic baud_tc;
    logic accept;

    assign baud_tc  = (baud_q == BAUD_LAST);
    assign tx_ready = (state_q == S_IDLE) && !rst;
    assign accept   = tx_valid && tx_ready;
    assign tx       = tx_q;
    assign busy     = busy_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            baud_q  <= 16'd0;
            bit_q   <= 3'd0;
            stop_q  <= 1'b0;
            shift_q <= 8'd0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            if (state_q == S_IDLE) begin
                baud_q <= 16'd0;
            end else begin
                baud_q <= baud_tc ? 16'd0 : baud_q + 16'd1;
            end

            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        // Parity is taken from the byte as latched, so later
                        // tx_data activity cannot disturb it.
                        shift_q <= tx_data;
                        par_q   <= (^tx_data) ^ ODD_BIT;
                        bit_q   <= 3'd0;
                        stop_q  <= 1'b0;
                        busy_q  <= 1'b1;
                        tx_q    <= 1'b0;
                        state_q <= S_START;
                    end
                end
                S_START: begin
                    if (baud_tc) begin
                        tx_q    <= shift_q[0];
                        state_q <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (baud_tc) begin
                        if (bit_q == 3'd7) begin
                            if (HAS_PAR) begin
                                tx_q    <= par_q;
                                state_q <= S_PARITY;
                            end else begin
                                tx_q    <= 1'b1;
                                state_q <= S_STOP;
                            end
                        end else begin
                            bit_q   <= bit_q + 3'd1;
                            shift_q <= shift_q >> 1;
                            tx_q    <= shift_q[1];
                        end
                    end
                end
                S_PARITY: begin
                    if (baud_tc) begin
                        tx_q    <= 1'b1;
                        state_q <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (baud_tc) begin
                        if (stop_q == STOP_LAST) begin
                            busy_q  <= 1'b0;
                            tx_q    <= 1'b1;
                            state_q <= S_IDLE;
                        end else begin
                            stop_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_oiia_uart_tx.sv
// Directed bench for oiia_uart_tx: four parameter variants, cycle-exact waveform
// checks plus a mid-bit sampling receiver model that decodes each frame.
module tb_oiia_uart_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'd0;
    logic [3:0] valid_w = 4'd0;
    logic [3:0] ready_w;
    logic [3:0] tx_w;
    logic [3:0] busy_w;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_cnt [4];

    // receiver model configuration and results
    int         rx_sel = 0;
    int         rx_n = 4;
    int         rx_pe = 0;
    int         rx_sb = 1;
    logic [7:0] rx_q [$];
    int         rx_par_q [$];
    int         rx_err_q [$];
    int         rx_start_q [$];

    always #5 clk = ~clk;

    // 0: N=4 no parity 1 stop; 1: even parity; 2: odd parity; 3: N=2, 2 stops
    oiia_uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_a (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(valid_w[0]),
        .tx_ready(ready_w[0]), .tx(tx_w[0]), .busy(busy_w[0]));
    oiia_uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_b (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(valid_w[1]),
        .tx_ready(ready_w[1]), .tx(tx_w[1]), .busy(busy_w[1]));
    oiia_uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_c (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(valid_w[2]),
        .tx_ready(ready_w[2]), .tx(tx_w[2]), .busy(busy_w[2]));
    oiia_uart_tx #(.CLKS_PER_BIT(2), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u_d (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(valid_w[3]),
        .tx_ready(ready_w[3]), .tx(tx_w[3]), .busy(busy_w[3]));

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int i = 0; i < 4; i++) begin
            if (!rst && valid_w[i] && ready_w[i]) acc_cnt[i] = acc_cnt[i] + 1;
        end
    end

    // Receiver model: detects a falling edge, samples each bit at its middle.
    initial begin : rx_model
        logic prev;
        logic active;
        int   cnt;
        int   total;
        int   k;
        logic [7:0] byte_v;
        int   par_v;
        int   err_v;
        prev = 1'b1;
        active = 1'b0;
        cnt = 0;
        byte_v = 8'd0;
        par_v = 0;
        err_v = 0;
        forever begin
            @(negedge clk);
            total = 9 + rx_pe + rx_sb;
            if (rst) begin
                active = 1'b0;
            end else if (!active && prev && !tx_w[rx_sel]) begin
                active = 1'b1;
                cnt = 0;
                err_v = 0;
                rx_start_q.push_back(cyc);
            end else if (active) begin
                cnt++;
                if (cnt % rx_n == rx_n / 2) begin
                    k = cnt / rx_n;
                    if (k == 0 && tx_w[rx_sel] != 1'b0) err_v++;
                    else if (k >= 1 && k <= 8) byte_v[k-1] = tx_w[rx_sel];
                    else if (k == 9 && rx_pe != 0) par_v = int'(tx_w[rx_sel]);
                    else if (k > 8 && tx_w[rx_sel] != 1'b1) err_v++;
                end
                if (cnt == total * rx_n - 1) begin
                    active = 1'b0;
                    rx_q.push_back(byte_v);
                    rx_par_q.push_back(par_v);
                    rx_err_q.push_back(err_v);
                end
            end
            prev = tx_w[rx_sel];
        end
    end

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic exp_bit(input logic [7:0] b, input int k, input int pe, input int po);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
        if (k == 9 && pe != 0) return (^b) ^ po[0];
        return 1'b1;
    endfunction

    task automatic rx_setup(input int sel, input int n, input int pe, input int sb);
        rx_sel = sel;
        rx_n = n;
        rx_pe = pe;
        rx_sb = sb;
        rx_q.delete();
        rx_par_q.delete();
        rx_err_q.delete();
        rx_start_q.delete();
    endtask

    // Sends one byte and checks the full waveform cycle by cycle.
    task automatic run_frame(input int sel, input logic [7:0] b, input int n, input int pe,
                             input int po, input int sb, input bit toggle);
        int f;
        int bad_tx;
        int bad_rdy;
        int busy_cyc;
        f = n * (9 + pe + sb);
        bad_tx = 0;
        bad_rdy = 0;
        busy_cyc = 0;
        rx_setup(sel, n, pe, sb);
        @(negedge clk);
        check("ready_before", int'(ready_w[sel]), 1);
        tx_data = b;
        valid_w[sel] = 1'b1;
        @(negedge clk);
        valid_w[sel] = 1'b0;
        for (int c = 0; c < f; c++) begin
            if (toggle) tx_data = 8'($urandom);
            if (tx_w[sel] !== exp_bit(b, c / n, pe, po)) bad_tx++;
            if (busy_w[sel] === 1'b1) busy_cyc++;
            if (ready_w[sel] !== 1'b0) bad_rdy++;
            @(negedge clk);
        end
        check("tx_wave", bad_tx, 0);
        check("busy_len", busy_cyc, f);
        check("ready_in_frame", bad_rdy, 0);
        check("busy_after", int'(busy_w[sel]), 0);
        check("ready_after", int'(ready_w[sel]), 1);
        check("rx_frames", rx_q.size(), 1);
        if (rx_q.size() > 0) begin
            check("rx_byte", int'(rx_q[0]), int'(b));
            check("rx_framing", rx_err_q[0], 0);
        end
        $display("frame dut%0d byte %02h len %0d busy %0d", sel, b, f, busy_cyc);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) acc_cnt[i] = 0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            check("rst_tx", int'(tx_w[i]), 1);
            check("rst_busy", int'(busy_w[i]), 0);
            check("rst_ready", int'(ready_w[i]), 0);
        end
        rst = 1'b0;

        // 0x55, no parity: 40-cycle frame
        run_frame(0, 8'h55, 4, 0, 0, 1, 1'b0);

        // even parity on 0x07 -> 1, odd -> 0
        run_frame(1, 8'h07, 4, 1, 0, 1, 1'b0);
        if (rx_par_q.size() > 0) check("parity_even", rx_par_q[0], 1);
        run_frame(2, 8'h07, 4, 1, 1, 1, 1'b0);
        if (rx_par_q.size() > 0) check("parity_odd", rx_par_q[0], 0);

        // two stop bits at N=2 on 0x00: 22 cycles
        run_frame(3, 8'h00, 2, 0, 0, 2, 1'b0);

        // tx_data scrambled during the frame must not matter
        run_frame(0, 8'hC3, 4, 0, 0, 1, 1'b1);

        // back-to-back with tx_valid held high
        begin : b2b
            int w;
            rx_setup(0, 4, 0, 1);
            acc_cnt[0] = 0;
            @(negedge clk);
            tx_data = 8'hA3;
            valid_w[0] = 1'b1;
            w = 0;
            while (acc_cnt[0] < 1 && w < 100) begin @(negedge clk); w++; end
            check("b2b_first_accept", acc_cnt[0], 1);
            tx_data = 8'h3C;
            w = 0;
            while (acc_cnt[0] < 2 && w < 100) begin @(negedge clk); w++; end
            check("b2b_second_accept", acc_cnt[0], 2);
            valid_w[0] = 1'b0;
            repeat (50) @(negedge clk);
            check("b2b_accept_total", acc_cnt[0], 2);
            check("b2b_frames", rx_q.size(), 2);
            if (rx_q.size() == 2) begin
                check("b2b_byte0", int'(rx_q[0]), 8'hA3);
                check("b2b_byte1", int'(rx_q[1]), 8'h3C);
                check("b2b_spacing", rx_start_q[1] - rx_start_q[0], 41);
            end
            $display("b2b dut0 accepts %0d frames %0d", acc_cnt[0], rx_q.size());
        end

        // reset during data bit 3 of 0xFF, with tx_valid also high
        begin : mid_rst
            rx_setup(0, 4, 0, 1);
            @(negedge clk);
            tx_data = 8'hFF;
            valid_w[0] = 1'b1;
            @(negedge clk);
            valid_w[0] = 1'b0;
            repeat (17) @(negedge clk);
            check("mid_busy", int'(busy_w[0]), 1);
            rst = 1'b1;
            valid_w[0] = 1'b1;
            acc_cnt[0] = 0;
            @(negedge clk);
            check("rst_abort_tx", int'(tx_w[0]), 1);
            check("rst_abort_busy", int'(busy_w[0]), 0);
            check("rst_abort_ready", int'(ready_w[0]), 0);
            check("rst_no_accept", acc_cnt[0], 0);
            valid_w[0] = 1'b0;
            rst = 1'b0;
            #1;
            check("rst_release_ready", int'(ready_w[0]), 1);
            $display("reset abort dut0 tx %0d busy %0d", tx_w[0], busy_w[0]);
        end
        run_frame(0, 8'h81, 4, 0, 0, 1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
